// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative EX-stage multiply/divide unit owning the HI/LO registers.
// A MULT/MULTU/DIV/DIVU runs for XLEN iterations on operand magnitudes, then
// a single fix-up cycle applies sign correction and commits the result to
// HI/LO. MTHI/MTLO are accepted only while idle. Any HI/LO access or new
// issue that arrives while an operation is in flight raises a stall.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  input  logic            hilo_rd,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [CW-1:0]       r_cnt;
  logic                r_isDiv;
  logic                r_negRes;
  logic                r_negRem;
  logic                r_divZero;
  logic [XLEN-1:0]     r_origRs;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_hi;
  logic [XLEN-1:0]     r_lo;
  logic                r_done;

  // Issue-time operand conditioning: signed ops (op[0]==0) work on magnitudes.
  logic                w_signedOp;
  logic                w_rsNeg;
  logic                w_rtNeg;
  logic [XLEN-1:0]     w_rsMag;
  logic [XLEN-1:0]     w_rtMag;

  // Per-iteration datapath for shift-add multiply and restoring divide.
  logic [XLEN:0]       w_addSum;
  logic [XLEN:0]       w_shift;
  logic                w_ge;
  logic [XLEN-1:0]     w_diff;

  // Sign-corrected results presented to HI/LO during FIX.
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quoFix;
  logic [XLEN-1:0]     w_remFix;
  logic [XLEN-1:0]     w_hiRes;
  logic [XLEN-1:0]     w_loRes;

  assign w_signedOp = ~op[0];
  assign w_rsNeg    = w_signedOp & rs_data[XLEN-1];
  assign w_rtNeg    = w_signedOp & rt_data[XLEN-1];
  assign w_rsMag    = w_rsNeg ? (~rs_data + 1'b1) : rs_data;
  assign w_rtMag    = w_rtNeg ? (~rt_data + 1'b1) : rt_data;

  assign w_addSum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  assign w_diff   = w_shift[XLEN-1:0] - r_b;

  assign w_prod   = r_negRes ? (~r_acc + 1'b1) : r_acc;
  assign w_quoFix = r_negRes ? (~r_quo + 1'b1) : r_quo;
  assign w_remFix = r_negRem ? (~r_rem + 1'b1) : r_rem;

  // Select what FIX commits: product halves, quotient/remainder, or the
  // divide-by-zero pattern that returns the untouched dividend.
  always_comb begin
    w_hiRes = w_prod[2*XLEN-1:XLEN];
    w_loRes = w_prod[XLEN-1:0];
    if (r_isDiv) begin
      if (r_divZero) begin
        w_hiRes = r_origRs;
        w_loRes = '1;
      end else begin
        w_hiRes = w_remFix;
        w_loRes = w_quoFix;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic; flush squashes an issue and aborts an in-flight op.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (start && !flush) w_nextState = CALC;
      CALC: begin
        if (flush)              w_nextState = IDLE;
        else if (r_cnt == '0)   w_nextState = FIX;
      end
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand latch at issue and one multiply or divide iteration per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_origRs  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
    end else if (r_state == IDLE) begin
      if (start && !flush) begin
        r_cnt     <= CW'(XLEN - 1);
        r_isDiv   <= op[1];
        r_negRes  <= w_rsNeg ^ w_rtNeg;
        r_negRem  <= w_rsNeg;
        r_divZero <= (rt_data == '0);
        r_origRs  <= rs_data;
        r_a       <= w_rsMag;
        r_b       <= w_rtMag;
        r_acc     <= {{XLEN{1'b0}}, w_rtMag};
        r_rem     <= '0;
        r_quo     <= w_rsMag;
      end
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_isDiv) begin
        r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], w_ge};
      end else begin
        r_acc <= {w_addSum, r_acc[XLEN-1:1]};
      end
    end
  end

  // HI/LO: committed at FIX unless flushed; MTHI/MTLO only land while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FIX) begin
      if (!flush) begin
        r_hi <= w_hiRes;
        r_lo <= w_loRes;
      end
    end else if (r_state == IDLE) begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  // Completion pulse for the cycle after a committed FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= (r_state == FIX) && !flush;
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign stall = busy & (start | hilo_rd | hi_we | lo_we);

endmodule
